// File: rtl/fifo_to_ram_dump_if.sv
// Stream bundle for fifo_to_ram_dump: write beats, dump commands and the dump output.
// The master modport is the traffic source/sink side and the slave modport is the dump engine.
interface fifo_to_ram_dump_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
);
    logic [AWIDTH+DWIDTH-1:0] i_tdata;
    logic                     i_tlast;
    logic                     i_tvalid;
    logic                     i_tready;
    logic [AWIDTH-1:0]        cmd_tdata;
    logic                     cmd_tvalid;
    logic                     cmd_tready;
    logic [DWIDTH-1:0]        o_tdata;
    logic                     o_tlast;
    logic                     o_tvalid;
    logic                     o_tready;

    modport master (
        output i_tdata, i_tlast, i_tvalid, cmd_tdata, cmd_tvalid, o_tready,
        input  i_tready, cmd_tready, o_tdata, o_tlast, o_tvalid
    );

    modport slave (
        input  i_tdata, i_tlast, i_tvalid, cmd_tdata, cmd_tvalid, o_tready,
        output i_tready, cmd_tready, o_tdata, o_tlast, o_tvalid
    );
endinterface

// File: rtl/fifo_to_ram_dump.sv
// Random-access writes into a dual-port RAM, dumped in address order 0..N as a stream with tlast.
// Define FIFO_TO_RAM_CLEAR_ON_READ_EN to zero each word as it is dumped (read-and-reset).
module ram_2port #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              wea_i,
    input  logic [AWIDTH-1:0] addra_i,
    input  logic [DWIDTH-1:0] dia_i,
    input  logic              enb_i,
    input  logic              web_i,
    input  logic [AWIDTH-1:0] addrb_i,
    input  logic [DWIDTH-1:0] dib_i,
    output logic [DWIDTH-1:0] dob_o
);
    logic [DWIDTH-1:0] mem_q [2**AWIDTH];
    logic [DWIDTH-1:0] dob_q;

    // Port B is read-first: dob_q captures the old word even when port B writes it.
    always_ff @(posedge clk) begin
        if (wea_i) mem_q[addra_i] <= dia_i;
        if (enb_i) begin
            dob_q <= mem_q[addrb_i];
            if (web_i) mem_q[addrb_i] <= dib_i;
        end
    end

    assign dob_o = dob_q;
endmodule

module fifo_to_ram_dump #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    fifo_to_ram_dump_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, DUMP, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [AWIDTH-1:0] last_addr_q, last_addr_d;
    logic              o_tvalid_q, o_tvalid_d;
    logic              o_tlast_q, o_tlast_d;
    logic              zero_q, zero_d;
    logic              idle, issue, wr_en, web;
    logic [DWIDTH-1:0] ram_dob;
    logic              unused_tlast;

    assign unused_tlast = bus.i_tlast;
    assign idle         = (state_q == IDLE);
    assign wr_en        = bus.i_tvalid & idle;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        last_addr_d = last_addr_q;
        o_tlast_d   = o_tlast_q;
        zero_d      = zero_q;
        issue       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_tvalid) begin
                    last_addr_d = bus.cmd_tdata;
                    rd_addr_d   = '0;
                    state_d     = DUMP;
                end
            end
            DUMP: begin
                issue = ~o_tvalid_q | bus.o_tready;
                if (issue) begin
                    rd_addr_d = rd_addr_q + AWIDTH'(1);
                    o_tlast_d = (rd_addr_q == last_addr_q);
                    zero_d    = 1'b0;
                    if (rd_addr_q == last_addr_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (o_tvalid_q & bus.o_tready & o_tlast_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // clear also suppresses the read so clear-on-read never zeroes an undumped word
        if (clear) begin
            state_d     = IDLE;
            rd_addr_d   = '0;
            last_addr_d = '0;
            o_tlast_d   = 1'b0;
            zero_d      = 1'b1;
            issue       = 1'b0;
        end
        o_tvalid_d = issue | (o_tvalid_q & ~bus.o_tready);
        if (clear) o_tvalid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            last_addr_q <= '0;
            o_tvalid_q  <= 1'b0;
            o_tlast_q   <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            last_addr_q <= last_addr_d;
            o_tvalid_q  <= o_tvalid_d;
            o_tlast_q   <= o_tlast_d;
            zero_q      <= zero_d;
        end
    end

`ifdef FIFO_TO_RAM_CLEAR_ON_READ_EN
    assign web = issue;
`else
    assign web = 1'b0;
`endif

    ram_2port #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_ram (
        .clk     (clk),
        .wea_i   (wr_en),
        .addra_i (bus.i_tdata[AWIDTH+DWIDTH-1:DWIDTH]),
        .dia_i   (bus.i_tdata[DWIDTH-1:0]),
        .enb_i   (issue),
        .web_i   (web),
        .addrb_i (rd_addr_q),
        .dib_i   ('0),
        .dob_o   (ram_dob)
    );

    // The RAM output register has no reset, so zero_q masks it until the first read after reset/clear.
    assign bus.o_tdata    = zero_q ? '0 : ram_dob;
    assign bus.o_tvalid   = o_tvalid_q;
    assign bus.o_tlast    = o_tlast_q;
    assign bus.i_tready   = idle;
    assign bus.cmd_tready = idle;
endmodule

// File: tb/tb_fifo_to_ram_dump.sv
// Directed + randomized bench for fifo_to_ram_dump against an array model of the RAM contents.
module tb_fifo_to_ram_dump;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total_cnt = 0;
    logic [DW-1:0] mem [DEPTH];

    fifo_to_ram_dump_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    fifo_to_ram_dump #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = {a, d};
        check("wr_ready", bus.i_tready, 1'b1);
        @(posedge clk); #1;
        bus.i_tvalid = 1'b0;
        mem[a] = d;
        $display("write addr=%0d data=0x%0h", a, d);
    endtask

    task automatic model_read_clear(input int a);
`ifdef FIFO_TO_RAM_CLEAR_ON_READ_EN
        mem[a] = '0;
`else
        if (a < 0) mem[0] = '0;
`endif
    endtask

    // mode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready
    // abort_kind: 0 none, 1 clear, 2 async reset, taken once abort_after beats were accepted
    task automatic run_dump(input int last, input int mode, input int abort_kind, input int abort_after);
        int   beats = 0;
        int   cyc = 0;
        int   budget;
        logic done = 1'b0;
        logic rdy;
        logic prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        logic [DW-1:0] exp_d;
        logic in_flight;

        check("cmd_ready", bus.cmd_tready, 1'b1);
        bus.cmd_tdata  = AW'(last);
        bus.cmd_tvalid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_tvalid = 1'b0;
        bus.i_tvalid   = 1'b0;
        check("lat_first_cycle", bus.o_tvalid, 1'b0);
        budget = 8 * (last + 1) + 20;
        while (!done && cyc < budget) begin
            if (cyc == 1) check("lat_second_cycle", bus.o_tvalid, 1'b1);
            check("inputs_blocked", {bus.i_tready, bus.cmd_tready}, 2'b00);
            if (prev_stall) begin
                check("stall_valid", bus.o_tvalid, 1'b1);
                check("stall_data", bus.o_tdata, prev_data);
                check("stall_last", bus.o_tlast, prev_last);
            end
            if (abort_kind != 0 && beats == abort_after) begin
                in_flight = bus.o_tvalid;
                if (in_flight) model_read_clear(beats);
                bus.o_tready = 1'b0;
                if (abort_kind == 1) begin
                    clear = 1'b1;
                    @(posedge clk); #1;
                    clear = 1'b0;
                end else begin
                    #2 reset = 1'b1;
                    #1;
                    check("rst_async_valid", bus.o_tvalid, 1'b0);
                    check("rst_async_last", bus.o_tlast, 1'b0);
                    check("rst_async_data", bus.o_tdata, '0);
                    #4 reset = 1'b0;
                    @(posedge clk); #1;
                end
                check("abort_valid", bus.o_tvalid, 1'b0);
                check("abort_last", bus.o_tlast, 1'b0);
                check("abort_data", bus.o_tdata, '0);
                check("abort_ready", {bus.i_tready, bus.cmd_tready}, 2'b11);
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    check("abort_quiet", {bus.o_tvalid, bus.o_tlast}, 2'b00);
                end
                $display("dump last=%0d aborted(kind=%0d) after %0d beats", last, abort_kind, beats);
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            bus.o_tready = rdy;
            if (bus.o_tvalid && rdy) begin
                exp_d = mem[beats];
                check("beat_data", bus.o_tdata, exp_d);
                check("beat_last", bus.o_tlast, (beats == last));
                model_read_clear(beats);
                beats++;
                if (bus.o_tlast) done = 1'b1;
            end
            prev_stall = bus.o_tvalid && !rdy;
            prev_data  = bus.o_tdata;
            prev_last  = bus.o_tlast;
            @(posedge clk); #1;
            cyc++;
        end
        bus.o_tready = 1'b0;
        check("dump_done", done, 1'b1);
        check("beat_count", beats, last + 1);
        check("idle_after_tlast", {bus.i_tready, bus.cmd_tready, bus.o_tvalid}, 3'b110);
        $display("dump last=%0d mode=%0d beats=%0d cycles=%0d", last, mode, beats, cyc);
    endtask

    initial begin
        int n;
        int l;
        bus.i_tdata    = '0;
        bus.i_tlast    = 1'b0;
        bus.i_tvalid   = 1'b0;
        bus.cmd_tdata  = '0;
        bus.cmd_tvalid = 1'b0;
        bus.o_tready   = 1'b0;

        #23 reset = 1'b0;
        @(posedge clk); #1;
        check("rst_valid", bus.o_tvalid, 1'b0);
        check("rst_last", bus.o_tlast, 1'b0);
        check("rst_data", bus.o_tdata, '0);
        check("rst_ready", {bus.i_tready, bus.cmd_tready}, 2'b11);

        for (int a = 0; a < DEPTH; a++) write_beat(AW'(a), DW'($urandom));

        write_beat(AW'(3), 32'hAAAA);
        write_beat(AW'(5), 32'hBBBB);
        write_beat(AW'(0), 32'h1111);
        run_dump(5, 0, 0, 0);

        run_dump(7, 1, 0, 0);

        bus.i_tvalid = 1'b1;
        bus.i_tdata  = {AW'(0), 32'hCAFE};
        mem[0] = 32'hCAFE;
        run_dump(0, 0, 0, 0);

        write_beat(AW'(1), DW'($urandom));
        run_dump(15, 0, 1, 4);
        run_dump(1, 0, 0, 0);

        run_dump(15, 0, 2, 6);
        run_dump(15, 2, 0, 0);

        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(0, 20);
            for (int w = 0; w < n; w++) write_beat(AW'($urandom_range(0, 63)), DW'($urandom));
            l = $urandom_range(0, 63);
            run_dump(l, 2, 0, 0);
        end

        run_dump(DEPTH - 1, 0, 0, 0);
        run_dump(3, 1, 0, 0);

        write_beat(AW'(2), 32'h55);
        run_dump(3, 0, 0, 0);
        run_dump(3, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
